ysyx_22040895_ex_issue: RTL and testbench
=========================================

// Module: ysyx_22040895_ex_issue
// PURPOSE
//  ID->EX issue stage feeding the ALU. Holds up to two decoded instructions (head + skid) with a valid/ready handshake.
//  Resolves RAW hazards: MEM/WB bypass, WB snoop into held entries, load-use interlock.
//  Drives the ALU operands (op1/op2, aluop, wordop, shift) plus rd and store data to EX.
// PARAMETERS
//  XLEN   64  datapath width
//  AOPW   4   aluop width (ALU encoding: add 0000 .. sltu 1001)
//  RAW    5   register index width
// PORTS
//  clk            in   1     clock, all state on rising edge
//  rst_n          in   1     asynchronous active-low reset
//  flush_i        in   1     branch redirect; kill all held entries
//  in_valid_i     in   1     ID has an instruction
//  in_ready_o     out  1     stage can accept (registered: skid slot empty)
//  id_pc_i        in   XLEN  instruction PC
//  id_rs1_i       in   RAW   source 1 index
//  id_rs2_i       in   RAW   source 2 index
//  id_rs1_data_i  in   XLEN  regfile read 1
//  id_rs2_data_i  in   XLEN  regfile read 2
//  id_imm_i       in   XLEN  sign-extended immediate
//  id_aluop_i     in   AOPW  ALU operation
//  id_op1_pc_i    in   1     op1 = PC instead of rs1
//  id_op2_imm_i   in   1     op2 = imm instead of rs2
//  id_wordop_i    in   1     *W instruction
//  id_shift_i     in   1     shift uses shamt field
//  id_rd_i        in   RAW   destination index
//  id_rd_we_i     in   1     writes rd
//  mem_rd_i       in   RAW   MEM-stage destination
//  mem_we_i       in   1     MEM-stage writes rd
//  mem_is_load_i  in   1     MEM-stage op is a load (data not yet valid)
//  mem_data_i     in   XLEN  MEM-stage ALU result
//  wb_rd_i        in   RAW   WB destination
//  wb_we_i        in   1     WB writes rd this cycle
//  wb_data_i      in   XLEN  WB write data
//  out_valid_o    out  1     head valid and hazard-free
//  out_ready_i    in   1     EX accepts head
//  aluop_o        out  AOPW  to ALU aluop
//  op1_o          out  XLEN  to ALU op1
//  op2_o          out  XLEN  to ALU op2
//  wordop_o       out  1     to ALU wordop
//  shift_o        out  1     to ALU shift
//  rd_o           out  RAW   destination index
//  rd_we_o        out  1     destination write enable (0 when !out_valid_o)
//  pc_o           out  XLEN  head PC
//  st_data_o      out  XLEN  forwarded rs2 (store data)
// BEHAVIOUR
//  - Reset (rst_n=0, async): head/skid invalid; in_ready_o=1; out_valid_o=0; all data outputs 0.
//  - States {EMPTY, HEAD, FULL}. Accept = in_valid_i & in_ready_o; fire = out_valid_o & out_ready_i.
//    EMPTY: accept->HEAD. HEAD: accept&!fire->FULL; fire&!accept->EMPTY; both->HEAD (new head).
//    FULL: fire->HEAD (skid moves to head); in_ready_o=0, no accept.
//  - Latency: 1 cycle ID accept -> out_valid_o when no hazard; full throughput 1/cycle.
//  - flush_i: both slots invalid next edge; same-cycle accept discarded; flush beats fire.
//  - Index 0 never matches any bypass, snoop or interlock; x0 reads as 0.
//  - Bypass per source: mem match & !mem_is_load_i -> mem_data_i; else wb match -> wb_data_i; else held data.
//  - Snoop: each edge, held entries whose rs matches wb (wb_we_i) overwrite stored rs data with wb_data_i.
//    The entry captured from ID in the same cycle also snoops.
//  - Load-use: head rs (as used) matches mem_rd_i with mem_we_i & mem_is_load_i -> out_valid_o=0, head held.
//  - Unused sources (op1_pc / op2_imm) never cause a stall.
//  - op1 = op1_pc ? pc : fwd(rs1); op2 = op2_imm ? imm : fwd(rs2); st_data_o = fwd(rs2) always.
//  - Outputs are combinational from the head slot; no ALU-result feedback; no width change (ALU sign-extends *W).
// CONFIGURATION
//  YSYX_22040895_BYPASS_EN defined: MEM/WB bypass as above; only load-use stalls.
//  Undefined: no bypass muxes; head stalls while any matching MEM or WB producer exists.
//    WB snoop remains, so a WB-matched stall clears the cycle after the write.
// STRUCTURE
//  - Shared include (define.v): XLEN/AOPW/RAW widths, aluop codes, state encodings.
//  - Sub-module ysyx_22040895_fwd_sel: per-source bypass select + hazard flag.
//    Instantiated for rs1 and rs2; top holds the slots and FSM.
// TESTING
//  - Reset mid-FULL: rst_n low 1 cycle -> out_valid_o=0, in_ready_o=1, rd_we_o=0 immediately (async).
//  - Back-to-back: addi x1=5 then add x2,x1,x1 with mem bypass 5 -> op1=op2=5, no bubble (BYPASS_EN).
//  - Load-use: ld x3 in MEM (mem_is_load_i=1) with head rs1=x3 -> 1 bubble; then wb 0x1234 -> op1=0x1234.
//  - Backpressure: out_ready_i=0 for 3 cycles with in_valid_i=1.
//    Result: FULL, in_ready_o=0, skid unchanged; release drains in order, PCs 0x80000000, 0x80000004.
//  - Flush in FULL with in_valid_i=1 -> next cycle EMPTY, out_valid_o=0, new instruction dropped.
//  - x0: mem_rd_i=0, mem_we_i=1, mem_data_i=0xFF, head rs1=x0 -> op1=0, no stall; repeat with macro undefined.

Source files
------------

// File: rtl/ysyx_22040895_ex_issue_pkg.sv
// Shared widths, ALU operation codes, issue FSM states and the held-entry
// record for the ID->EX issue stage, plus the register-match and WB-snoop
// helpers used by both slots.
package ysyx_22040895_ex_issue_pkg;

    localparam int XLEN = 64;
    localparam int AOPW = 4;
    localparam int RAW  = 5;

    // ALU operation encoding seen on aluop_o
    localparam logic [AOPW-1:0] ALU_ADD  = 4'b0000;
    localparam logic [AOPW-1:0] ALU_SUB  = 4'b0001;
    localparam logic [AOPW-1:0] ALU_SLL  = 4'b0010;
    localparam logic [AOPW-1:0] ALU_XOR  = 4'b0011;
    localparam logic [AOPW-1:0] ALU_SRL  = 4'b0100;
    localparam logic [AOPW-1:0] ALU_SRA  = 4'b0101;
    localparam logic [AOPW-1:0] ALU_OR   = 4'b0110;
    localparam logic [AOPW-1:0] ALU_AND  = 4'b0111;
    localparam logic [AOPW-1:0] ALU_SLT  = 4'b1000;
    localparam logic [AOPW-1:0] ALU_SLTU = 4'b1001;

    // Slot occupancy: EMPTY (nothing held), HEAD (head only), FULL (head + skid)
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HEAD  = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    // One decoded instruction as held in the head or skid slot
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [RAW-1:0]  rs1;
        logic [RAW-1:0]  rs2;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [AOPW-1:0] aluop;
        logic            op1_pc;
        logic            op2_imm;
        logic            wordop;
        logic            shift;
        logic [RAW-1:0]  rd;
        logic            rd_we;
    } entry_t;

    // A producer matches a source only when it writes and the index is not x0
    function automatic logic rs_match(input logic [RAW-1:0] rs,
                                      input logic [RAW-1:0] rd,
                                      input logic           we);
        return we && (rs == rd) && (rs != '0);
    endfunction

    // Refresh stored source data with the value WB is writing this cycle
    function automatic entry_t snoop_entry(input entry_t          e,
                                           input logic            wb_we,
                                           input logic [RAW-1:0]  wb_rd,
                                           input logic [XLEN-1:0] wb_data);
        entry_t r;
        r = e;
        if (rs_match(e.rs1, wb_rd, wb_we)) r.rs1_data = wb_data;
        if (rs_match(e.rs2, wb_rd, wb_we)) r.rs2_data = wb_data;
        return r;
    endfunction

endpackage

// File: rtl/ysyx_22040895_ex_issue_if.sv
// Bus bundle of the issue stage: the ID-side instruction handshake, the
// MEM/WB producer taps used for bypass and snoop, and the EX-side operand
// handshake. The slave modport is the issue stage; master is its surroundings.
//
// Handshake rule for both sides: a transfer happens on a rising edge where
// valid and ready are both 1; valid never depends on ready of the same side,
// and a held-but-not-transferred item stays stable until it transfers or is
// flushed.
interface ysyx_22040895_ex_issue_if;
    import ysyx_22040895_ex_issue_pkg::*;

    // ID -> issue
    logic            in_valid_i;
    logic            in_ready_o;
    logic [XLEN-1:0] id_pc_i;
    logic [RAW-1:0]  id_rs1_i;
    logic [RAW-1:0]  id_rs2_i;
    logic [XLEN-1:0] id_rs1_data_i;
    logic [XLEN-1:0] id_rs2_data_i;
    logic [XLEN-1:0] id_imm_i;
    logic [AOPW-1:0] id_aluop_i;
    logic            id_op1_pc_i;
    logic            id_op2_imm_i;
    logic            id_wordop_i;
    logic            id_shift_i;
    logic [RAW-1:0]  id_rd_i;
    logic            id_rd_we_i;

    // MEM / WB producers
    logic [RAW-1:0]  mem_rd_i;
    logic            mem_we_i;
    logic            mem_is_load_i;
    logic [XLEN-1:0] mem_data_i;
    logic [RAW-1:0]  wb_rd_i;
    logic            wb_we_i;
    logic [XLEN-1:0] wb_data_i;

    // issue -> EX
    logic            out_valid_o;
    logic            out_ready_i;
    logic [AOPW-1:0] aluop_o;
    logic [XLEN-1:0] op1_o;
    logic [XLEN-1:0] op2_o;
    logic            wordop_o;
    logic            shift_o;
    logic [RAW-1:0]  rd_o;
    logic            rd_we_o;
    logic [XLEN-1:0] pc_o;
    logic [XLEN-1:0] st_data_o;

    modport slave (
        input  in_valid_i, id_pc_i, id_rs1_i, id_rs2_i, id_rs1_data_i,
               id_rs2_data_i, id_imm_i, id_aluop_i, id_op1_pc_i,
               id_op2_imm_i, id_wordop_i, id_shift_i, id_rd_i, id_rd_we_i,
               mem_rd_i, mem_we_i, mem_is_load_i, mem_data_i,
               wb_rd_i, wb_we_i, wb_data_i, out_ready_i,
        output in_ready_o, out_valid_o, aluop_o, op1_o, op2_o, wordop_o,
               shift_o, rd_o, rd_we_o, pc_o, st_data_o
    );

    modport master (
        output in_valid_i, id_pc_i, id_rs1_i, id_rs2_i, id_rs1_data_i,
               id_rs2_data_i, id_imm_i, id_aluop_i, id_op1_pc_i,
               id_op2_imm_i, id_wordop_i, id_shift_i, id_rd_i, id_rd_we_i,
               mem_rd_i, mem_we_i, mem_is_load_i, mem_data_i,
               wb_rd_i, wb_we_i, wb_data_i, out_ready_i,
        input  in_ready_o, out_valid_o, aluop_o, op1_o, op2_o, wordop_o,
               shift_o, rd_o, rd_we_o, pc_o, st_data_o
    );

endinterface

// File: rtl/ysyx_22040895_ex_issue_fwd_sel.sv
// Per-source operand select and hazard flag for the head instruction.
// Build option YSYX_22040895_BYPASS_EN: when defined, MEM (non-load) and WB
// results are bypassed and only a load in MEM stalls; when undefined, the
// held value is used and any matching MEM or WB producer stalls the source.
module ysyx_22040895_ex_issue_fwd_sel
    import ysyx_22040895_ex_issue_pkg::*;
(
    input  logic [RAW-1:0]  rs_i,
    input  logic [XLEN-1:0] held_i,
    input  logic            used_i,
    input  logic [RAW-1:0]  mem_rd_i,
    input  logic            mem_we_i,
    input  logic            mem_is_load_i,
    input  logic [XLEN-1:0] mem_data_i,
    input  logic [RAW-1:0]  wb_rd_i,
    input  logic            wb_we_i,
    input  logic [XLEN-1:0] wb_data_i,
    output logic [XLEN-1:0] data_o,
    output logic            stall_o
);

    logic mem_hit;
    logic wb_hit;

    assign mem_hit = rs_match(rs_i, mem_rd_i, mem_we_i);
    assign wb_hit  = rs_match(rs_i, wb_rd_i, wb_we_i);

`ifdef YSYX_22040895_BYPASS_EN
    // Youngest non-load producer wins; x0 always reads as zero
    always_comb begin
        data_o = held_i;
        if (rs_i == '0)
            data_o = '0;
        else if (mem_hit && !mem_is_load_i)
            data_o = mem_data_i;
        else if (wb_hit)
            data_o = wb_data_i;
    end

    // Only a load still in MEM cannot be bypassed
    assign stall_o = used_i & mem_hit & mem_is_load_i;
`else
    // No bypass network: the held (snooped) value is the operand
    always_comb begin
        data_o = held_i;
        if (rs_i == '0)
            data_o = '0;
    end

    // Wait until every in-flight producer of this source has retired
    assign stall_o = used_i & (mem_hit | wb_hit);

    logic unused_fwd;
    assign unused_fwd = ^{mem_is_load_i, mem_data_i, wb_data_i};
`endif

endmodule

// File: rtl/ysyx_22040895_ex_issue.sv
// ID->EX issue stage: a head slot plus one skid slot behind a valid/ready
// handshake, RAW hazard handling (bypass, WB snoop, load-use interlock) and
// ALU operand formation for EX. Build option YSYX_22040895_BYPASS_EN selects
// the MEM/WB bypass network inside the per-source select blocks.
module ysyx_22040895_ex_issue
    import ysyx_22040895_ex_issue_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush_i,
    ysyx_22040895_ex_issue_if.slave     stage_io,
    output state_e                      dbg_state_o
);

    state_e state_q, state_d;
    entry_t head_q, head_d;
    entry_t skid_q, skid_d;

    entry_t id_entry;
    entry_t id_snooped;

    logic            head_vld;
    logic            accept;
    logic            fire;
    logic [XLEN-1:0] fwd_rs1;
    logic [XLEN-1:0] fwd_rs2;
    logic            stall_rs1;
    logic            stall_rs2;

    assign head_vld    = (state_q != ST_EMPTY);
    assign dbg_state_o = state_q;

    // Skid slot empty means another instruction can be taken
    assign stage_io.in_ready_o = (state_q != ST_FULL);
    assign accept = stage_io.in_valid_i & stage_io.in_ready_o;
    assign fire   = stage_io.out_valid_o & stage_io.out_ready_i;

    // Pack the ID bundle into a slot record
    always_comb begin
        id_entry          = '0;
        id_entry.pc       = stage_io.id_pc_i;
        id_entry.rs1      = stage_io.id_rs1_i;
        id_entry.rs2      = stage_io.id_rs2_i;
        id_entry.rs1_data = stage_io.id_rs1_data_i;
        id_entry.rs2_data = stage_io.id_rs2_data_i;
        id_entry.imm      = stage_io.id_imm_i;
        id_entry.aluop    = stage_io.id_aluop_i;
        id_entry.op1_pc   = stage_io.id_op1_pc_i;
        id_entry.op2_imm  = stage_io.id_op2_imm_i;
        id_entry.wordop   = stage_io.id_wordop_i;
        id_entry.shift    = stage_io.id_shift_i;
        id_entry.rd       = stage_io.id_rd_i;
        id_entry.rd_we    = stage_io.id_rd_we_i;
    end

    // The incoming instruction catches a WB write that lands on the same edge
    assign id_snooped = snoop_entry(id_entry, stage_io.wb_we_i,
                                    stage_io.wb_rd_i, stage_io.wb_data_i);

    // Slot FSM next state and slot contents; flush overrides everything
    always_comb begin
        state_d = state_q;
        head_d  = snoop_entry(head_q, stage_io.wb_we_i, stage_io.wb_rd_i,
                              stage_io.wb_data_i);
        skid_d  = snoop_entry(skid_q, stage_io.wb_we_i, stage_io.wb_rd_i,
                              stage_io.wb_data_i);
        unique case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    head_d  = id_snooped;
                    state_d = ST_HEAD;
                end
            end
            ST_HEAD: begin
                if (accept && !fire) begin
                    skid_d  = id_snooped;
                    state_d = ST_FULL;
                end else if (fire && !accept) begin
                    state_d = ST_EMPTY;
                end else if (fire && accept) begin
                    head_d  = id_snooped;
                end
            end
            ST_FULL: begin
                if (fire) begin
                    head_d  = skid_d;
                    state_d = ST_HEAD;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        if (flush_i)
            state_d = ST_EMPTY;
    end

    // Slot and state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            head_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
        end
    end

    ysyx_22040895_ex_issue_fwd_sel u_fwd_rs1 (
        .rs_i          (head_q.rs1),
        .held_i        (head_q.rs1_data),
        .used_i        (!head_q.op1_pc),
        .mem_rd_i      (stage_io.mem_rd_i),
        .mem_we_i      (stage_io.mem_we_i),
        .mem_is_load_i (stage_io.mem_is_load_i),
        .mem_data_i    (stage_io.mem_data_i),
        .wb_rd_i       (stage_io.wb_rd_i),
        .wb_we_i       (stage_io.wb_we_i),
        .wb_data_i     (stage_io.wb_data_i),
        .data_o        (fwd_rs1),
        .stall_o       (stall_rs1)
    );

    ysyx_22040895_ex_issue_fwd_sel u_fwd_rs2 (
        .rs_i          (head_q.rs2),
        .held_i        (head_q.rs2_data),
        .used_i        (!head_q.op2_imm),
        .mem_rd_i      (stage_io.mem_rd_i),
        .mem_we_i      (stage_io.mem_we_i),
        .mem_is_load_i (stage_io.mem_is_load_i),
        .mem_data_i    (stage_io.mem_data_i),
        .wb_rd_i       (stage_io.wb_rd_i),
        .wb_we_i       (stage_io.wb_we_i),
        .wb_data_i     (stage_io.wb_data_i),
        .data_o        (fwd_rs2),
        .stall_o       (stall_rs2)
    );

    // EX-side outputs come straight from the head slot, zeroed when empty
    always_comb begin
        stage_io.out_valid_o = head_vld & ~stall_rs1 & ~stall_rs2;
        stage_io.aluop_o     = '0;
        stage_io.op1_o       = '0;
        stage_io.op2_o       = '0;
        stage_io.wordop_o    = 1'b0;
        stage_io.shift_o     = 1'b0;
        stage_io.rd_o        = '0;
        stage_io.pc_o        = '0;
        stage_io.st_data_o   = '0;
        if (head_vld) begin
            stage_io.aluop_o   = head_q.aluop;
            stage_io.op1_o     = head_q.op1_pc  ? head_q.pc  : fwd_rs1;
            stage_io.op2_o     = head_q.op2_imm ? head_q.imm : fwd_rs2;
            stage_io.wordop_o  = head_q.wordop;
            stage_io.shift_o   = head_q.shift;
            stage_io.rd_o      = head_q.rd;
            stage_io.pc_o      = head_q.pc;
            stage_io.st_data_o = fwd_rs2;
        end
        stage_io.rd_we_o = stage_io.out_valid_o & head_q.rd_we;
    end

endmodule

// File: tb/tb_ysyx_22040895_ex_issue.sv
// Directed bench for the ID->EX issue stage: reset, back-to-back bypass,
// load-use, backpressure drain order, flush and x0 handling. Expectations
// follow whichever YSYX_22040895_BYPASS_EN setting the build uses.
module tb_ysyx_22040895_ex_issue;
    import ysyx_22040895_ex_issue_pkg::*;

    logic   clk;
    logic   rst_n;
    logic   flush;
    state_e dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    logic [63:0] exp_q[$];
    bit sb_en = 1'b0;

    ysyx_22040895_ex_issue_if bus ();

    ysyx_22040895_ex_issue dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (flush),
        .stage_io    (bus),
        .dbg_state_o (dbg_state)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drive_id(input logic [63:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [63:0] d1, input logic [63:0] d2, input logic [63:0] imm,
                            input logic [3:0] op, input logic op1_pc, input logic op2_imm,
                            input logic wordop, input logic shift, input logic [4:0] rd,
                            input logic rd_we);
        bus.in_valid_i    = 1'b1;
        bus.id_pc_i       = pc;
        bus.id_rs1_i      = rs1;
        bus.id_rs2_i      = rs2;
        bus.id_rs1_data_i = d1;
        bus.id_rs2_data_i = d2;
        bus.id_imm_i      = imm;
        bus.id_aluop_i    = op;
        bus.id_op1_pc_i   = op1_pc;
        bus.id_op2_imm_i  = op2_imm;
        bus.id_wordop_i   = wordop;
        bus.id_shift_i    = shift;
        bus.id_rd_i       = rd;
        bus.id_rd_we_i    = rd_we;
    endtask

    task automatic idle_id();
        bus.in_valid_i = 1'b0;
        bus.id_pc_i = '0; bus.id_rs1_i = '0; bus.id_rs2_i = '0;
        bus.id_rs1_data_i = '0; bus.id_rs2_data_i = '0; bus.id_imm_i = '0;
        bus.id_aluop_i = '0; bus.id_op1_pc_i = 1'b0; bus.id_op2_imm_i = 1'b0;
        bus.id_wordop_i = 1'b0; bus.id_shift_i = 1'b0; bus.id_rd_i = '0;
        bus.id_rd_we_i = 1'b0;
    endtask

    task automatic clear_fwd();
        bus.mem_rd_i = '0; bus.mem_we_i = 1'b0; bus.mem_is_load_i = 1'b0; bus.mem_data_i = '0;
        bus.wb_rd_i = '0; bus.wb_we_i = 1'b0; bus.wb_data_i = '0;
    endtask

    // scoreboard: PCs leaving the stage in order while enabled
    always @(negedge clk) begin
        if (sb_en && bus.out_valid_o && bus.out_ready_i) begin
            if (exp_q.size() > 0)
                check("drain_pc", bus.pc_o, exp_q.pop_front());
            else
                check("drain_underflow", 64'(exp_q.size()), 64'd1);
        end
    end

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        idle_id();
        clear_fwd();
        bus.out_ready_i = 1'b1;
        #2;
        check("rst_out_valid", 64'(bus.out_valid_o), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready_o), 64'd1);
        check("rst_rd_we", 64'(bus.rd_we_o), 64'd0);
        check("rst_op1", bus.op1_o, 64'd0);
        check("rst_state", 64'(dbg_state), 64'(ST_EMPTY));
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        // back-to-back: addi x1,x0,5 then add x2,x1,x1
        tick();
        drive_id(64'h100, 5'd0, 5'd0, 64'd0, 64'd0, 64'd5, ALU_ADD, 1'b0, 1'b1, 1'b0, 1'b0, 5'd1, 1'b1);
        tick();
        drive_id(64'h104, 5'd1, 5'd1, 64'd0, 64'd0, 64'd0, ALU_ADD, 1'b0, 1'b0, 1'b0, 1'b0, 5'd2, 1'b1);
        settle();
        check("b2b_addi_valid", 64'(bus.out_valid_o), 64'd1);
        check("b2b_addi_op1", bus.op1_o, 64'd0);
        check("b2b_addi_op2", bus.op2_o, 64'd5);
        check("b2b_addi_rd", 64'(bus.rd_o), 64'd1);
        tick();
        idle_id();
        bus.mem_rd_i = 5'd1; bus.mem_we_i = 1'b1; bus.mem_data_i = 64'd5;
        settle();
`ifdef YSYX_22040895_BYPASS_EN
        check("b2b_add_valid", 64'(bus.out_valid_o), 64'd1);
        check("b2b_add_op1", bus.op1_o, 64'd5);
        check("b2b_add_op2", bus.op2_o, 64'd5);
        check("b2b_add_st", bus.st_data_o, 64'd5);
        check("b2b_add_rd", 64'(bus.rd_o), 64'd2);
`else
        check("b2b_mem_stall", 64'(bus.out_valid_o), 64'd0);
        check("b2b_mem_stall_we", 64'(bus.rd_we_o), 64'd0);
        tick();
        clear_fwd();
        bus.wb_rd_i = 5'd1; bus.wb_we_i = 1'b1; bus.wb_data_i = 64'd5;
        settle();
        check("b2b_wb_stall", 64'(bus.out_valid_o), 64'd0);
        tick();
        clear_fwd();
        settle();
        check("b2b_add_valid", 64'(bus.out_valid_o), 64'd1);
        check("b2b_add_op1", bus.op1_o, 64'd5);
        check("b2b_add_op2", bus.op2_o, 64'd5);
        check("b2b_add_st", bus.st_data_o, 64'd5);
`endif
        tick();
        clear_fwd();
        settle();
        check("b2b_drained", 64'(bus.out_valid_o), 64'd0);

        // load-use: ld x3 in MEM, head addiw x4,x3,0x10
        drive_id(64'h200, 5'd3, 5'd0, 64'd0, 64'd0, 64'h10, ALU_ADD, 1'b0, 1'b1, 1'b1, 1'b0, 5'd4, 1'b1);
        tick();
        idle_id();
        bus.mem_rd_i = 5'd3; bus.mem_we_i = 1'b1; bus.mem_is_load_i = 1'b1; bus.mem_data_i = 64'hdead;
        settle();
        check("lu_bubble", 64'(bus.out_valid_o), 64'd0);
        tick();
        clear_fwd();
        bus.wb_rd_i = 5'd3; bus.wb_we_i = 1'b1; bus.wb_data_i = 64'h1234;
        settle();
`ifdef YSYX_22040895_BYPASS_EN
        check("lu_valid", 64'(bus.out_valid_o), 64'd1);
        check("lu_op1", bus.op1_o, 64'h1234);
        check("lu_op2", bus.op2_o, 64'h10);
        check("lu_wordop", 64'(bus.wordop_o), 64'd1);
`else
        check("lu_wb_stall", 64'(bus.out_valid_o), 64'd0);
        tick();
        clear_fwd();
        settle();
        check("lu_valid", 64'(bus.out_valid_o), 64'd1);
        check("lu_op1", bus.op1_o, 64'h1234);
        check("lu_wordop", 64'(bus.wordop_o), 64'd1);
`endif
        tick();
        clear_fwd();
        settle();
        check("lu_drained", 64'(bus.out_valid_o), 64'd0);

        // backpressure: EX stalls three cycles while ID keeps offering
        bus.out_ready_i = 1'b0;
        drive_id(64'h80000000, 5'd0, 5'd0, 64'd0, 64'd0, 64'd4, ALU_ADD, 1'b1, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1);
        tick();
        drive_id(64'h80000004, 5'd0, 5'd0, 64'd0, 64'd0, 64'd4, ALU_ADD, 1'b1, 1'b1, 1'b0, 1'b0, 5'd6, 1'b1);
        settle();
        check("bp_head_valid", 64'(bus.out_valid_o), 64'd1);
        check("bp_in_ready_head", 64'(bus.in_ready_o), 64'd1);
        check("bp_op1_pc", bus.op1_o, 64'h80000000);
        tick();
        drive_id(64'h80000008, 5'd0, 5'd0, 64'd0, 64'd0, 64'd4, ALU_ADD, 1'b1, 1'b1, 1'b0, 1'b0, 5'd7, 1'b1);
        settle();
        check("bp_state_full", 64'(dbg_state), 64'(ST_FULL));
        for (int i = 0; i < 2; i++) begin
            check("bp_in_ready_full", 64'(bus.in_ready_o), 64'd0);
            check("bp_pc_held", bus.pc_o, 64'h80000000);
            tick();
        end
        idle_id();
        exp_q.push_back(64'h80000000);
        exp_q.push_back(64'h80000004);
        sb_en = 1'b1;
        bus.out_ready_i = 1'b1;
        settle();
        check("bp_rel_shift", 64'(bus.shift_o), 64'd1);
        tick();
        settle();
        check("bp_skid_rd", 64'(bus.rd_o), 64'd6);
        tick();
        settle();
        check("bp_drained", 64'(bus.out_valid_o), 64'd0);
        check("bp_sb_empty", 64'(exp_q.size()), 64'd0);
        sb_en = 1'b0;

        // flush in FULL with ID offering another instruction
        bus.out_ready_i = 1'b0;
        drive_id(64'h300, 5'd0, 5'd0, 64'd0, 64'd0, 64'd1, ALU_OR, 1'b0, 1'b1, 1'b0, 1'b0, 5'd8, 1'b1);
        tick();
        drive_id(64'h304, 5'd0, 5'd0, 64'd0, 64'd0, 64'd1, ALU_OR, 1'b0, 1'b1, 1'b0, 1'b0, 5'd8, 1'b1);
        tick();
        drive_id(64'h308, 5'd0, 5'd0, 64'd0, 64'd0, 64'd1, ALU_OR, 1'b0, 1'b1, 1'b0, 1'b0, 5'd8, 1'b1);
        flush = 1'b1;
        settle();
        check("fl_full_before", 64'(dbg_state), 64'(ST_FULL));
        tick();
        flush = 1'b0;
        idle_id();
        settle();
        check("fl_valid", 64'(bus.out_valid_o), 64'd0);
        check("fl_in_ready", 64'(bus.in_ready_o), 64'd1);
        check("fl_state", 64'(dbg_state), 64'(ST_EMPTY));

        // flush in HEAD discards the instruction accepted on the same edge
        drive_id(64'h400, 5'd0, 5'd0, 64'd0, 64'd0, 64'd1, ALU_AND, 1'b0, 1'b1, 1'b0, 1'b0, 5'd9, 1'b1);
        tick();
        drive_id(64'h404, 5'd0, 5'd0, 64'd0, 64'd0, 64'd1, ALU_AND, 1'b0, 1'b1, 1'b0, 1'b0, 5'd9, 1'b1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        idle_id();
        settle();
        check("fl_head_state", 64'(dbg_state), 64'(ST_EMPTY));
        check("fl_head_valid", 64'(bus.out_valid_o), 64'd0);
        bus.out_ready_i = 1'b1;

        // x0 never matches MEM/WB and reads as zero
        drive_id(64'h500, 5'd0, 5'd0, 64'h55, 64'h66, 64'd7, ALU_ADD, 1'b0, 1'b1, 1'b0, 1'b0, 5'd10, 1'b1);
        tick();
        idle_id();
        bus.mem_rd_i = 5'd0; bus.mem_we_i = 1'b1; bus.mem_data_i = 64'hFF;
        bus.wb_rd_i = 5'd0; bus.wb_we_i = 1'b1; bus.wb_data_i = 64'hEE;
        settle();
        check("x0_valid", 64'(bus.out_valid_o), 64'd1);
        check("x0_op1", bus.op1_o, 64'd0);
        check("x0_st", bus.st_data_o, 64'd0);
        tick();
        clear_fwd();

        // asynchronous reset while FULL
        bus.out_ready_i = 1'b0;
        drive_id(64'h600, 5'd0, 5'd0, 64'd0, 64'd0, 64'd2, ALU_ADD, 1'b0, 1'b1, 1'b0, 1'b0, 5'd11, 1'b1);
        tick();
        drive_id(64'h604, 5'd0, 5'd0, 64'd0, 64'd0, 64'd2, ALU_ADD, 1'b0, 1'b1, 1'b0, 1'b0, 5'd12, 1'b1);
        tick();
        idle_id();
        settle();
        check("rstf_full", 64'(dbg_state), 64'(ST_FULL));
        #1;
        rst_n = 1'b0;
        #1;
        check("rstf_valid", 64'(bus.out_valid_o), 64'd0);
        check("rstf_in_ready", 64'(bus.in_ready_o), 64'd1);
        check("rstf_rd_we", 64'(bus.rd_we_o), 64'd0);
        check("rstf_op2", bus.op2_o, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready_i = 1'b1;
        tick();
        settle();
        check("rstf_after", 64'(bus.out_valid_o), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // global time bound
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
